spi_rx: RTL and testbench

SPI_RX -- requirements
Module: spi_rx

---
 rtl/spi_rx_pkg.sv | 14 +
 rtl/spi_rx_sync.sv | 34 +++
 rtl/spi_rx.sv | 194 +++++++++++++++++++
 tb/tb_spi_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared SPI definitions: frame width common to transmitter and receiver,
// and the receiver state encoding.
package spi_rx_pkg;

  localparam int SPI_FRAME_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Two-flop synchronizer plus one delay flop for a single asynchronous line,
// with rise/fall detection on the synchronized value.
module spi_rx_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver: clk-domain sampling of spi_clk/cs/sdi, DATA_W-bit MSB-first
// frames, with short-frame, overrun and timeout error detection.
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W  = SPI_FRAME_W,
  parameter int TIMEOUT = 4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              sdi,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic sclk_rise;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic sdi_bit;
  logic unused_sclk_level;
  logic unused_sclk_fall;
  logic unused_sdi_rise;
  logic unused_sdi_fall;

  spi_rx_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (spi_clk),
    .level (unused_sclk_level),
    .rise  (sclk_rise),
    .fall  (unused_sclk_fall)
  );

  spi_rx_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_rx_sync #(.RESET_VAL(1'b0)) u_sync_sdi (
    .clk   (clk),
    .reset (reset),
    .din   (sdi),
    .level (sdi_bit),
    .rise  (unused_sdi_rise),
    .fall  (unused_sdi_fall)
  );

  spi_state_t        state;
  spi_state_t        state_next;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              overrun;
  logic [1:0]        settle;
  logic              armed;
  logic              timed_out;

  logic do_start;
  logic do_shift;
  logic do_load;
  logic fe_next;
  logic set_overrun;

  assign timed_out = (to_cnt == TO_W'(TIMEOUT));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cs rise always wins over a same-cycle spi_clk rise; timeout only when the line is quiet
  always_comb begin
    state_next  = state;
    do_start    = 1'b0;
    do_shift    = 1'b0;
    do_load     = 1'b0;
    fe_next     = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_next = SHIFT;
          do_start   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
          fe_next    = 1'b1;
        end else if (sclk_rise) begin
          do_shift = 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            state_next = FULL;
          end
        end else if (timed_out) begin
          state_next = DRAIN;
          fe_next    = 1'b1;
        end
      end
      FULL: begin
        if (cs_rise) begin
          state_next = IDLE;
          do_load    = 1'b1;
        end else if (sclk_rise) begin
          state_next  = DRAIN;
          set_overrun = 1'b1;
        end else if (timed_out) begin
          state_next = DRAIN;
          fe_next    = 1'b1;
        end
      end
      DRAIN: begin
        if (cs_rise) begin
          state_next = IDLE;
          fe_next    = overrun;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // armed waits for the cs synchronizer to flush after reset, so a cs that is
  // still low from an aborted frame cannot masquerade as a fresh cs fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end else if (cs_level) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      overrun    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= do_load;
      frame_err  <= fe_next;

      if (do_start) begin
        bit_cnt <= '0;
        overrun <= 1'b0;
      end else if (do_shift) begin
        sreg    <= {sreg[DATA_W-2:0], sdi_bit};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (set_overrun) begin
        overrun <= 1'b1;
      end

      if (do_start) begin
        to_cnt <= '0;
      end else if (state == SHIFT || state == FULL) begin
        if (sclk_rise) begin
          to_cnt <= '0;
        end else if (!timed_out) begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end

      if (do_load) begin
        data_out <= sreg;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx.sv
// Randomized self-checking bench for spi_rx with a frame-level reference model.
module tb_spi_rx;

  localparam int DW = 10;
  localparam int TO = 4000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_clk = 1'b0;
  logic          cs = 1'b1;
  logic          sdi = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  spi_rx #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .cs         (cs),
    .sdi        (sdi),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_dv = 0;
  int n_fe = 0;
  int exp_dv_cyc = -1;
  int exp_fe_cyc = -1;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] dv_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame closed by cs rise pulses on the 3rd clk edge sampling cs high;
  // exactly DW counted rises gives data_valid with the bits MSB first, otherwise frame_err.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_data_valid", 32'(data_valid), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end else begin
      if (cyc == exp_dv_cyc) exp_data = pend_data;
      chk("data_valid", 32'(data_valid), 32'(cyc == exp_dv_cyc));
      chk("frame_err", 32'(frame_err), 32'(cyc == exp_fe_cyc));
      chk("data_out", 32'(data_out), 32'(exp_data));
      if (data_valid) begin
        n_dv++;
        dv_log.push_back(data_out);
      end
      if (frame_err) n_fe++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sdi = word[nbits-1-i];
      wait_n($urandom_range(1, 3));
      spi_clk = 1'b1;
      wait_n($urandom_range(1, 3));
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] word, input int nbits, input bit tie,
                       input int gap, input bit noise);
    cs = 1'b0;
    wait_n(3);
    send_bits(word, nbits);
    wait_n($urandom_range(1, 3));
    if (tie) spi_clk = 1'b1;
    cs = 1'b1;
    if (nbits == DW) begin
      pend_data  = word[DW-1:0];
      exp_dv_cyc = cyc + 3;
    end else begin
      exp_fe_cyc = cyc + 3;
    end
    wait_n(1);
    for (int k = 0; k < gap - 2; k++) begin
      if (noise) begin
        spi_clk = 1'($urandom);
        sdi     = 1'($urandom);
      end else begin
        spi_clk = 1'b0;
      end
      wait_n(1);
    end
    spi_clk = 1'b0;
    wait_n(1);
  endtask

  initial begin
    int dv0;
    int fe0;
    int nb;
    logic [31:0] w;

    wait_n(4);
    chk("reset_data_out_lit", 32'(data_out), 32'h0);
    chk("reset_busy_lit", 32'(busy), 32'h0);
    reset = 1'b0;
    wait_n(6);

    // full frame
    dv0 = n_dv; fe0 = n_fe;
    frame(32'h2A5, DW, 1'b0, 6, 1'b1);
    chk("full_data_lit", 32'(data_out), 32'h2A5);
    chk("full_dv_count", 32'(n_dv - dv0), 32'd1);
    chk("full_fe_count", 32'(n_fe - fe0), 32'd0);

    // short frame
    dv0 = n_dv; fe0 = n_fe;
    frame(32'h2F, 6, 1'b0, 6, 1'b1);
    chk("short_data_lit", 32'(data_out), 32'h2A5);
    chk("short_fe_count", 32'(n_fe - fe0), 32'd1);
    chk("short_dv_count", 32'(n_dv - dv0), 32'd0);

    // overrun
    dv0 = n_dv; fe0 = n_fe;
    frame(32'h5A3, 11, 1'b0, 6, 1'b1);
    chk("ovr_fe_count", 32'(n_fe - fe0), 32'd1);
    chk("ovr_dv_count", 32'(n_dv - dv0), 32'd0);

    // timeout: SHIFT entered 3 edges after the cs fall drive, pulse TO+1 cycles later
    fe0 = n_fe;
    cs = 1'b0;
    exp_fe_cyc = cyc + 4 + TO;
    wait_n(TO + 10);
    chk("to_busy_held", 32'(busy), 32'd1);
    chk("to_fe_count", 32'(n_fe - fe0), 32'd1);
    cs = 1'b1;
    wait_n(5);
    chk("to_busy_release", 32'(busy), 32'd0);
    chk("to_fe_count_after", 32'(n_fe - fe0), 32'd1);
    wait_n(2);

    // mid-frame reset with cs held low
    dv0 = n_dv; fe0 = n_fe;
    cs = 1'b0;
    wait_n(3);
    send_bits(32'h3C, 4);
    wait_n(2);
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    exp_data = '0;
    wait_n(2);
    reset = 1'b0;
    send_bits(32'h15, 5);
    wait_n(3);
    chk("mid_busy_after", 32'(busy), 32'd0);
    cs = 1'b1;
    wait_n(6);
    chk("mid_no_pulse", 32'((n_dv - dv0) + (n_fe - fe0)), 32'd0);
    frame(32'h155, DW, 1'b0, 6, 1'b0);
    chk("mid_data_lit", 32'(data_out), 32'h155);

    // back-to-back with minimum cs high time
    dv0 = n_dv;
    frame(32'h3FF, DW, 1'b0, 4, 1'b0);
    frame(32'h000, DW, 1'b0, 6, 1'b0);
    chk("b2b_dv_count", 32'(n_dv - dv0), 32'd2);
    if (dv_log.size() >= 2) begin
      chk("b2b_first", 32'(dv_log[dv_log.size()-2]), 32'h3FF);
      chk("b2b_second", 32'(dv_log[dv_log.size()-1]), 32'h000);
    end else begin
      chk("b2b_log_size", 32'(dv_log.size()), 32'd2);
    end

    // cs rise coinciding with a spi_clk rise: that rise is not counted
    fe0 = n_fe;
    frame(32'h1B7, 9, 1'b1, 6, 1'b1);
    chk("tie_short_fe", 32'(n_fe - fe0), 32'd1);
    dv0 = n_dv;
    frame(32'h0C9, DW, 1'b1, 6, 1'b1);
    chk("tie_full_dv", 32'(n_dv - dv0), 32'd1);
    chk("tie_full_data", 32'(data_out), 32'h0C9);

    // random frames
    for (int f = 0; f < 40; f++) begin
      w  = $urandom;
      nb = ($urandom_range(0, 2) != 0) ? DW : int'($urandom_range(0, 13));
      frame(w, nb, ($urandom_range(0, 7) == 0), int'($urandom_range(4, 9)), 1'($urandom));
    end
    wait_n(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
